pwm_ramp_driver: RTL and testbench

PWM_RAMP_DRIVER -- requirements
Module: pwm_ramp_driver

---
 rtl/pwm_ramp_driver.sv | 87 ++++++++
 tb/tb_pwm_ramp_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_driver.sv
// Multi-channel PWM driver for traffic-light lamps: a shared period counter and
// per-channel duty registers that ramp toward a state-selected target once per period.
module pwm_ramp_driver #(
   parameter int unsigned CHANNELS    = 3,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned PERIOD      = 100,
   parameter int unsigned DUTY_RED    = 10,
   parameter int unsigned DUTY_GREEN  = 90,
   parameter int unsigned DUTY_YELLOW = 50,
   parameter int unsigned RAMP_STEP   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [2*CHANNELS-1:0] traffic_state,
   output logic [CHANNELS-1:0]   pwm_out,
   output logic [CHANNELS-1:0]   ramp_busy,
   output logic                  period_tick
);

   // One extra bit so a duty equal to PERIOD = 2^CNT_W is representable.
   localparam int unsigned DUTY_W   = CNT_W + 1;
   localparam int unsigned T_RED    = (DUTY_RED    > PERIOD) ? PERIOD : DUTY_RED;
   localparam int unsigned T_GREEN  = (DUTY_GREEN  > PERIOD) ? PERIOD : DUTY_GREEN;
   localparam int unsigned T_YELLOW = (DUTY_YELLOW > PERIOD) ? PERIOD : DUTY_YELLOW;

   localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0]                 cnt;
   logic [CHANNELS-1:0][DUTY_W-1:0]  cur_duty;
   logic [CHANNELS-1:0][DUTY_W-1:0]  tgt;
   logic [CHANNELS-1:0][DUTY_W-1:0]  tgt_nxt;
   logic [CHANNELS-1:0][DUTY_W-1:0]  duty_nxt;
   logic                             boundary;

   // Target decode and saturating one-step move toward it, evaluated every cycle.
   always_comb begin
      boundary = en && (cnt == CNT_LAST);
      tgt_nxt  = '0;
      duty_nxt = cur_duty;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         case (traffic_state[2*i +: 2])
            2'b00:   tgt_nxt[i] = DUTY_W'(T_RED);
            2'b01:   tgt_nxt[i] = DUTY_W'(T_GREEN);
            2'b10:   tgt_nxt[i] = DUTY_W'(T_YELLOW);
            default: tgt_nxt[i] = '0;
         endcase
         if (tgt_nxt[i] > cur_duty[i]) begin
            duty_nxt[i] = ((tgt_nxt[i] - cur_duty[i]) <= STEP) ? tgt_nxt[i]
                                                                 : cur_duty[i] + STEP;
         end else if (tgt_nxt[i] < cur_duty[i]) begin
            duty_nxt[i] = ((cur_duty[i] - tgt_nxt[i]) <= STEP) ? tgt_nxt[i]
                                                                 : cur_duty[i] - STEP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         cur_duty    <= '0;
         tgt         <= '0;
         pwm_out     <= '0;
         ramp_busy   <= '0;
         period_tick <= 1'b0;
      end else if (en) begin
         cnt         <= boundary ? '0 : cnt + CNT_W'(1);
         period_tick <= boundary;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            pwm_out[i] <= ({1'b0, cnt} < cur_duty[i]);
         end
         // Targets and duties only move at the period boundary.
         if (boundary) begin
            tgt      <= tgt_nxt;
            cur_duty <= duty_nxt;
            for (int i = 0; i < int'(CHANNELS); i++) begin
               ramp_busy[i] <= (duty_nxt[i] != tgt_nxt[i]);
            end
         end
      end else begin
         pwm_out     <= '0;
         period_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_ramp_driver.sv
// Directed bench for pwm_ramp_driver: measures per-period high time of each channel
// against a small ramp model, plus a short-period saturated instance.
module tb_pwm_ramp_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [5:0] ts;
   logic [2:0] pwm;
   logic [2:0] busy;
   logic       tick;
   logic [1:0] ts2;
   logic [0:0] pwm2;
   logic [0:0] busy2;
   logic       tick2;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_duty [3];
   int exp_tgt  [3];

   always #5 clk = ~clk;

   pwm_ramp_driver dut (
      .clk(clk), .rst(rst), .en(en), .traffic_state(ts),
      .pwm_out(pwm), .ramp_busy(busy), .period_tick(tick)
   );

   pwm_ramp_driver #(.CHANNELS(1), .PERIOD(4), .DUTY_GREEN(200), .RAMP_STEP(4)) dut2 (
      .clk(clk), .rst(rst), .en(en), .traffic_state(ts2),
      .pwm_out(pwm2), .ramp_busy(busy2), .period_tick(tick2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int target_of(input logic [1:0] s);
      case (s)
         2'b00:   return 10;
         2'b01:   return 90;
         2'b10:   return 50;
         default: return 0;
      endcase
   endfunction

   // Reference ramp: move by at most 5 counts toward the target.
   task automatic model_boundary();
      for (int c = 0; c < 3; c++) begin
         int d;
         exp_tgt[c] = target_of(ts[2*c +: 2]);
         d = exp_tgt[c] - exp_duty[c];
         if (d > 5)  d = 5;
         if (d < -5) d = -5;
         exp_duty[c] = exp_duty[c] + d;
      end
   endtask

   task automatic check_busy(input string tag);
      logic [2:0] eb;
      for (int c = 0; c < 3; c++) eb[c] = (exp_duty[c] != exp_tgt[c]);
      check(tag, 32'(busy), 32'(eb));
   endtask

   // Starts at the sample where period_tick is high, counts high samples over one period.
   task automatic period_check(input int chg_at, input logic [5:0] chg_val,
                               input int pause_at, input int pause_len);
      int hi [3];
      int w;
      w = 0;
      while (tick !== 1'b1 && w < 300) begin
         step();
         w++;
      end
      check("tick_wait", 32'(tick), 32'd1);
      model_boundary();
      check_busy("busy_after_boundary");
      for (int c = 0; c < 3; c++) hi[c] = 0;
      for (int k = 0; k < 100; k++) begin
         if (k == chg_at) ts = chg_val;
         if (k == pause_at) begin
            en = 1'b0;
            repeat (pause_len) begin
               step();
               check("pause_pwm", 32'(pwm), 32'd0);
               check("pause_tick", 32'(tick), 32'd0);
            end
            en = 1'b1;
         end
         step();
         for (int c = 0; c < 3; c++) hi[c] += int'(pwm[c]);
      end
      for (int c = 0; c < 3; c++) check($sformatf("duty_ch%0d", c), 32'(hi[c]), 32'(exp_duty[c]));
      check("period_end_tick", 32'(tick), 32'd1);
   endtask

   initial begin
      int w;
      rst = 1'b1;
      en  = 1'b0;
      ts  = 6'b00_00_00;
      ts2 = 2'b01;
      for (int c = 0; c < 3; c++) begin
         exp_duty[c] = 0;
         exp_tgt[c]  = 0;
      end
      repeat (3) step();
      check("rst_pwm", 32'(pwm), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_pwm2", 32'(pwm2), 32'd0);

      rst = 1'b0;
      en  = 1'b1;

      // Short-period instance: clamped target reached in one step, then solid high.
      w = 0;
      do begin
         step();
         w++;
         if (tick2 !== 1'b1) check("dut2_pre_low", 32'(pwm2), 32'd0);
      end while (tick2 !== 1'b1 && w < 20);
      check("dut2_tick", 32'(tick2), 32'd1);
      check("dut2_busy", 32'(busy2), 32'd0);
      for (int k = 1; k <= 12; k++) begin
         step();
         check("dut2_high", 32'(pwm2), 32'd1);
         check("dut2_tick_cadence", 32'(tick2), ((k % 4) == 0) ? 32'd1 : 32'd0);
      end

      // All RED from reset: 5 then 10.
      period_check(-1, 6'd0, -1, 0);
      period_check(-1, 6'd0, -1, 0);
      // Mid-period change to GREEN/GREEN/YELLOW; no effect this period.
      period_check(40, 6'b10_01_01, -1, 0);
      repeat (5) period_check(-1, 6'd0, -1, 0);
      // Ch1 at 40 reverses to OFF.
      period_check(30, 6'b10_11_01, -1, 0);
      repeat (9) period_check(-1, 6'd0, -1, 0);
      // Ch0 steady at 90, switched to RED mid-period.
      period_check(50, 6'b10_11_00, -1, 0);
      repeat (16) period_check(-1, 6'd0, -1, 0);
      // Enable dropped for 37 cycles mid-period.
      period_check(-1, 6'd0, 20, 37);
      period_check(30, 6'b10_11_01, -1, 0);

      // Reset pulse at cnt=57 during ch0 ramp.
      check("pre_rst_tick", 32'(tick), 32'd1);
      model_boundary();
      check_busy("busy_before_rst");
      repeat (57) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_pwm", 32'(pwm), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_tick", 32'(tick), 32'd0);
      for (int c = 0; c < 3; c++) begin
         exp_duty[c] = 0;
         exp_tgt[c]  = 0;
      end
      period_check(-1, 6'd0, -1, 0);
      period_check(-1, 6'd0, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
